fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter ILEN, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Parameter QDEPTH, default 4, fetch-queue entries; power of two, >= 2.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 imem_req  output  1  instruction-memory read request this cycle.
REQ-008 imem_addr  output  XLEN  read address, valid when imem_req=1.
REQ-009 imem_rdata  input  ILEN  read data, valid exactly one cycle after the request.
REQ-010 redirect_valid  input  1  branch/jump taken; flush and redirect this cycle.
REQ-011 redirect_pc  input  XLEN  redirect target.
REQ-012 id_valid  output  1  queue head valid toward decode.
REQ-013 id_ready  input  1  decode accepts the head.
REQ-014 id_pc  output  XLEN  PC of the head instruction.
REQ-015 id_instr  output  ILEN  head instruction.
REQ-016 q_count  output  $clog2(QDEPTH+1)  current queue occupancy.

Function
REQ-017 Internal fetch PC register pc; imem_addr SHALL equal pc combinationally.
REQ-018 imem_req SHALL be 1 iff redirect_valid=0 and (q_count + inflight) < QDEPTH, where inflight=1 if a request was issued last cycle and not discarded.
REQ-019 On an issued request, pc SHALL advance to pc+4, modulo 2^XLEN (wraps from all-ones region to 0, no error).
REQ-020 Issued request's PC SHALL be held in an in-flight register; next cycle {inflight_pc, imem_rdata} SHALL be pushed to queue tail.
REQ-021 Queue is FIFO; id_valid = (q_count != 0) and redirect_valid=0; id_pc/id_instr SHALL show head entry.
REQ-022 Pop occurs iff id_valid=1 and id_ready=1; head advances next cycle.
REQ-023 Simultaneous push and pop SHALL leave q_count unchanged and preserve order.
REQ-024 Push into full queue SHALL never occur (guaranteed by REQ-018); pop from empty SHALL never occur (id_valid=0).
REQ-025 Read/write pointers SHALL wrap modulo QDEPTH.
REQ-026 No bypass: pushed entry SHALL become visible on id_* the cycle after push.
REQ-027 Fetch-to-decode latency: request in cycle t -> id_valid for that entry in cycle t+2 at earliest.
REQ-028 Sustained throughput SHALL be one instruction per cycle while id_ready=1 and no redirect.
REQ-029 redirect_valid=1 has priority over all: pc <= {redirect_pc[XLEN-1:2], 2'b00}; queue emptied (q_count <= 0, pointers reset); in-flight response of that cycle discarded; no request issued; no pop.
REQ-030 Redirect in consecutive cycles: last one wins; fetch resumes the cycle after redirect_valid falls.
REQ-031 Stall via id_ready=0 SHALL fill queue to QDEPTH then hold imem_req=0; no entry lost or duplicated.

Reset
REQ-032 Reset asserted: pc=RESET_PC, q_count=0, pointers=0, inflight=0, imem_req=0, id_valid=0, asynchronously.
REQ-033 Reset mid-operation SHALL discard queue and in-flight request; first request after release at RESET_PC in first clock edge cycle.
REQ-034 Queue data storage need not be reset.

Verification
REQ-035 Reset release, id_ready=1, imem returns addr-as-data -> id_pc 0,4,8,... one per cycle from cycle 2, id_instr==id_pc.
REQ-036 id_ready=0 for 10 cycles, QDEPTH=4 -> q_count reaches 4, imem_req=0 afterwards; release -> PCs 0,4,8,12,16 in order, no gaps.
REQ-037 redirect_valid with redirect_pc=0x103 while queue holds 3 entries -> q_count=0 next cycle, next imem_addr=0x100, first id_pc=0x100, old PCs never appear.
REQ-038 RESET_PC=0xFFFFFFF8 -> imem_addr sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-039 Reset asserted mid-stream with in-flight request -> q_count=0, id_valid=0 immediately, restart at RESET_PC.
REQ-040 Random id_ready/redirect with scoreboard model -> every delivered (pc,instr) matches model, no overflow, q_count never > QDEPTH.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generator, one-cycle-latency imem interface and a
// small FIFO of (pc, instr) pairs feeding decode. Redirect flushes everything in flight.
module fetch_unit #(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      ILEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int unsigned      QDEPTH   = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic                         imem_req,
   output logic [XLEN-1:0]              imem_addr,
   input  logic [ILEN-1:0]              imem_rdata,
   input  logic                         redirect_valid,
   input  logic [XLEN-1:0]              redirect_pc,
   output logic                         id_valid,
   input  logic                         id_ready,
   output logic [XLEN-1:0]              id_pc,
   output logic [ILEN-1:0]              id_instr,
   output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

   localparam int unsigned CW = $clog2(QDEPTH + 1);
   localparam int unsigned PW = $clog2(QDEPTH);
   localparam logic [CW:0] DEPTH_W = QDEPTH[CW:0];

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;
   logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW:0]     occupancy;
   logic            push, pop;

   logic [XLEN-1:0] pc_mem    [QDEPTH];
   logic [ILEN-1:0] instr_mem [QDEPTH];

   // Target is word-aligned; the low two bits are intentionally ignored.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   always_comb begin
      occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
      imem_addr = pc_q;
      // Counting the in-flight slot guarantees a response always has room in the queue.
      imem_req  = !reset && !redirect_valid && (occupancy < DEPTH_W);
      push      = inflight_q && !redirect_valid;
      id_valid  = (count_q != '0) && !redirect_valid;
      pop       = id_valid && id_ready;
      id_pc     = pc_mem[rptr_q];
      id_instr  = instr_mem[rptr_q];
      q_count   = count_q;
   end

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = imem_req;
      inflight_pc_d = inflight_pc_q;
      wptr_d        = wptr_q;
      rptr_d        = rptr_q;
      count_d       = count_q;
      if (redirect_valid) begin
         pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (imem_req) begin
            pc_d          = pc_q + XLEN'(4);
            inflight_pc_d = pc_q;
         end
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         count_q       <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem[wptr_q]    <= inflight_pc_q;
         instr_mem[wptr_q] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirect, PC wrap and a short
// randomised run against an in-order expected-PC model.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic        imem_req, w_req;
   logic [31:0] imem_addr, w_addr;
   logic [31:0] imem_rdata, w_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid, w_id_valid;
   logic        id_ready;
   logic [31:0] id_pc, w_id_pc;
   logic [31:0] id_instr, w_id_instr;
   logic [2:0]  q_count, w_q_count;
   logic [31:0] mask;
   logic [31:0] exp_pc;

   int checks = 0;
   int errors = 0;

   fetch_unit u_dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .q_count        (q_count)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clock          (clock),
      .reset          (reset),
      .imem_req       (w_req),
      .imem_addr      (w_addr),
      .imem_rdata     (w_rdata),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .id_valid       (w_id_valid),
      .id_ready       (1'b1),
      .id_pc          (w_id_pc),
      .id_instr       (w_id_instr),
      .q_count        (w_q_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memory: data is the address xor mask, returned one cycle after the request.
   always @(posedge clock) begin
      imem_rdata <= imem_addr ^ mask;
      w_rdata    <= w_addr;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b0;
      mask           = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_qcount", q_count, 0);
      chk("rst_idvalid", id_valid, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

      // Streaming with addr-as-data
      @(posedge clock); #1 reset = 1'b0; id_ready = 1'b1;
      @(negedge clock);
      chk("c0_req", imem_req, 1);
      chk("c0_addr", imem_addr, 0);
      chk("c0_idvalid", id_valid, 0);
      chk("c0_wrap_addr", w_addr, 32'hFFFF_FFF8);
      @(negedge clock);
      chk("c1_addr", imem_addr, 4);
      chk("c1_idvalid", id_valid, 0);
      chk("c1_wrap_addr", w_addr, 32'hFFFF_FFFC);
      @(negedge clock);
      chk("c2_wrap_addr", w_addr, 32'h0000_0000);
      chk("c2_wrap_idpc", w_id_pc, 32'hFFFF_FFF8);
      for (int k = 0; k < 6; k++) begin
         if (k != 0) @(negedge clock);
         chk("stream_valid", id_valid, 1);
         chk("stream_pc", id_pc, 32'(4 * k));
         chk("stream_instr", id_instr, 32'(4 * k));
         chk("stream_qcount", q_count, 1);
      end

      // Reset with a request in flight
      @(posedge clock); #1 reset = 1'b1;
      #1;
      chk("midrst_qcount", q_count, 0);
      chk("midrst_idvalid", id_valid, 0);
      chk("midrst_req", imem_req, 0);
      chk("midrst_addr", imem_addr, 0);
      mask = 32'hDEAD_0000;
      id_ready = 1'b0;

      // Stall: queue fills to 4 then fetch stops
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      chk("restart_addr", imem_addr, 0);
      chk("restart_req", imem_req, 1);
      repeat (9) @(negedge clock);
      chk("stall_qcount", q_count, 4);
      chk("stall_req", imem_req, 0);
      chk("stall_idpc", id_pc, 0);
      @(posedge clock); #1 id_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         chk("drain_valid", id_valid, 1);
         chk("drain_pc", id_pc, 32'(4 * k));
         chk("drain_instr", id_instr, 32'(4 * k) ^ mask);
      end

      // Redirect with three entries queued
      @(posedge clock); #1 reset = 1'b1; id_ready = 1'b0;
      @(posedge clock); #1 reset = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      chk("pre_redir_qcount", q_count, 3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      #1;
      chk("redir_req", imem_req, 0);
      chk("redir_idvalid", id_valid, 0);
      @(posedge clock); #1 redirect_valid = 1'b0; id_ready = 1'b1;
      @(negedge clock);
      chk("post_redir_qcount", q_count, 0);
      chk("post_redir_addr", imem_addr, 32'h100);
      chk("post_redir_req", imem_req, 1);
      @(negedge clock);
      chk("post_redir_idvalid", id_valid, 0);
      chk("post_redir_addr2", imem_addr, 32'h104);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("redir_stream_valid", id_valid, 1);
         chk("redir_stream_pc", id_pc, 32'h100 + 32'(4 * k));
         chk("redir_stream_instr", id_instr, (32'h100 + 32'(4 * k)) ^ mask);
      end

      // Back-to-back redirects: the last target wins
      @(posedge clock); #1 redirect_valid = 1'b1; redirect_pc = 32'h200;
      @(negedge clock);
      chk("dbl_redir_idvalid", id_valid, 0);
      chk("dbl_redir_req", imem_req, 0);
      @(posedge clock); #1 redirect_pc = 32'h305;
      @(negedge clock);
      chk("dbl_redir_req2", imem_req, 0);
      @(posedge clock); #1 redirect_valid = 1'b0;
      @(negedge clock);
      chk("dbl_redir_addr", imem_addr, 32'h304);
      chk("dbl_redir_resume", imem_req, 1);
      chk("dbl_redir_qcount", q_count, 0);
      @(negedge clock);
      chk("dbl_redir_lat", id_valid, 0);
      @(negedge clock);
      chk("dbl_redir_valid", id_valid, 1);
      chk("dbl_redir_pc", id_pc, 32'h304);

      // Random backpressure and redirects against the expected in-order PC stream
      exp_pc = 32'h308;
      for (int n = 0; n < 400; n++) begin
         @(posedge clock); #1;
         id_ready       = 1'($urandom_range(0, 1));
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom;
         @(negedge clock);
         chk("rnd_qcount_bound", (q_count <= 3'd4), 1);
         if (redirect_valid) begin
            chk("rnd_redir_idvalid", id_valid, 0);
            chk("rnd_redir_req", imem_req, 0);
            exp_pc = {redirect_pc[31:2], 2'b00};
         end else if (id_valid && id_ready) begin
            chk("rnd_pc", id_pc, exp_pc);
            chk("rnd_instr", id_instr, exp_pc ^ mask);
            exp_pc = exp_pc + 32'd4;
         end
      end
      @(posedge clock); #1 redirect_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
